// File: rtl/converter_frame_ctrl.sv
// Frame sequencer for the converter shift buffer: syncs c4/f0 into clk50, issues per-bit shift strobes and frame interrupts.
// Optional `CONV_RESYNC_EN: an f0 frame pulse arriving mid-frame restarts the frame instead of only flagging it.
module converter_frame_ctrl #(
   parameter int FRAME_BITS = 384,
   parameter int CNT_W      = 9,
   parameter int C4_PER_BIT = 2
) (
   input  logic             clk50,
   input  logic             reset_rg,
   input  logic             c4,
   input  logic             f0,
   input  logic             select,
   input  logic             int_ack,
   output logic             shift_en,
   output logic [CNT_W-1:0] bit_idx,
   output logic             dir,
   output logic             frame_done,
   output logic             cpu_int,
   output logic             overrun,
   output logic             sync_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0]       PH_LAST  = 4'(C4_PER_BIT - 1);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_BITS - 1);

   state_t           state_q, state_d;
   logic [2:0]       c4_sync_q, c4_sync_d;
   logic [2:0]       f0_sync_q, f0_sync_d;
   logic [3:0]       phase_q, phase_d;
   logic [CNT_W-1:0] nxt_q, nxt_d;
   logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
   logic             shift_en_q, shift_en_d;
   logic             dir_q, dir_d;
   logic             frame_done_q, frame_done_d;
   logic             cpu_int_q, cpu_int_d;
   logic             overrun_q, overrun_d;
   logic             sync_err_q, sync_err_d;
   logic             c4_fall, f0_start;

   // [1] is the synchronised level, [2] its one-cycle history
   assign c4_fall  = c4_sync_q[2] & ~c4_sync_q[1];
   assign f0_start = f0_sync_q[2] & ~f0_sync_q[1];

   always_comb begin
      c4_sync_d    = {c4_sync_q[1:0], c4};
      f0_sync_d    = {f0_sync_q[1:0], f0};
      state_d      = state_q;
      phase_d      = phase_q;
      nxt_d        = nxt_q;
      bit_idx_d    = bit_idx_q;
      dir_d        = dir_q;
      shift_en_d   = 1'b0;
      frame_done_d = 1'b0;
      cpu_int_d    = cpu_int_q;
      overrun_d    = overrun_q;
      sync_err_d   = sync_err_q;
      // Acknowledge is applied first so a flag set in the same cycle wins.
      if (int_ack) begin
         cpu_int_d  = 1'b0;
         overrun_d  = 1'b0;
         sync_err_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (f0_start) begin
               state_d   = RUN;
               dir_d     = select;
               phase_d   = '0;
               nxt_d     = '0;
               bit_idx_d = '0;
            end
         end
         RUN: begin
            // f0 has priority; a coincident c4 edge is dropped
            if (f0_start) begin
               sync_err_d = 1'b1;
`ifdef CONV_RESYNC_EN
               dir_d      = select;
               phase_d    = '0;
               nxt_d      = '0;
               bit_idx_d  = '0;
`endif
            end else if (c4_fall) begin
               if (phase_q == PH_LAST) begin
                  phase_d    = '0;
                  shift_en_d = 1'b1;
                  bit_idx_d  = nxt_q;
                  nxt_d      = nxt_q + 1'b1;
                  if (nxt_q == IDX_LAST) state_d = DONE;
               end else begin
                  phase_d = phase_q + 4'd1;
               end
            end
         end
         DONE: begin
            frame_done_d = 1'b1;
            cpu_int_d    = 1'b1;
            if (cpu_int_q) overrun_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk50) begin
      if (reset_rg) begin
         state_q      <= IDLE;
         c4_sync_q    <= '0;
         f0_sync_q    <= '0;
         phase_q      <= '0;
         nxt_q        <= '0;
         bit_idx_q    <= '0;
         shift_en_q   <= 1'b0;
         dir_q        <= 1'b0;
         frame_done_q <= 1'b0;
         cpu_int_q    <= 1'b0;
         overrun_q    <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         c4_sync_q    <= c4_sync_d;
         f0_sync_q    <= f0_sync_d;
         phase_q      <= phase_d;
         nxt_q        <= nxt_d;
         bit_idx_q    <= bit_idx_d;
         shift_en_q   <= shift_en_d;
         dir_q        <= dir_d;
         frame_done_q <= frame_done_d;
         cpu_int_q    <= cpu_int_d;
         overrun_q    <= overrun_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign shift_en   = shift_en_q;
   assign bit_idx    = bit_idx_q;
   assign dir        = dir_q;
   assign frame_done = frame_done_q;
   assign cpu_int    = cpu_int_q;
   assign overrun    = overrun_q;
   assign sync_err   = sync_err_q;
endmodule

// File: doc/converter_frame_ctrl.md
# converter_frame_ctrl

Frame sequencer for the 384-bit converter shift buffer, running in the `clk50` domain.
- Synchronises the TDM bit clock `c4` and frame pulse `f0` into `clk50`.
- Produces one shift strobe per TDM bit, the bit index and the latched transfer direction.
- Raises `cpu_int` once per completed frame for the CPU to service.
- Sits between the backplane TDM pins and the shift buffer that moves data between the DT and STM sides.

## Interface
- `FRAME_BITS`, 384: bits per frame (shift strobes per frame).
- `CNT_W`, 9: width of `bit_idx`; must satisfy 2^CNT_W ≥ FRAME_BITS.
- `C4_PER_BIT`, 2: `c4` falling edges per TDM bit; legal range 1..15.

Ports (reset is synchronous and active-high):
- `clk50`  in  1  system clock, 50 MHz.
- `reset_rg`  in  1  reset.
- `c4`  in  1  asynchronous TDM clock.
- `f0`  in  1  asynchronous frame pulse, active-low.
- `select`  in  1  requested direction: 0 = STM→DT, 1 = DT→STM.
- `int_ack`  in  1  one-cycle CPU acknowledge.
- `shift_en`  out  1  one-cycle strobe per bit.
- `bit_idx`  out  CNT_W  index of the bit being strobed, 0..FRAME_BITS-1.
- `dir`  out  1  `select` latched at frame start.
- `frame_done`  out  1  one-cycle pulse on frame completion.
- `cpu_int`  out  1  level interrupt.
- `overrun`  out  1  sticky: a frame completed while `cpu_int` was still set.
- `sync_err`  out  1  sticky: `f0` arrived mid-frame.

## Operation
Input conditioning:
- `c4` and `f0` each pass through a 2-flop synchroniser followed by a history flop.
- `c4_fall` = synchronised `c4` falling edge.
- `f0_start` = synchronised `f0` falling edge.

FSM states and transitions:
- IDLE → RUN on `f0_start`.
  - Latch `dir` ← `select`.
  - Clear the phase counter and `bit_idx`.
- RUN: each `c4_fall` increments phase.
  - When phase reaches C4_PER_BIT-1: pulse `shift_en` with the current `bit_idx`, then phase ← 0 and `bit_idx` ← `bit_idx`+1.
  - After the strobe with `bit_idx` = FRAME_BITS-1, go to DONE.
- DONE, for one cycle:
  - Pulse `frame_done`.
  - If `cpu_int` is already 1, set `overrun`.
  - Set `cpu_int`.
  - Go to IDLE.
- `f0_start` while in RUN:
  - Set `sync_err`.
  - Further behaviour is set by `CONV_RESYNC_EN` (see Configuration).

Interrupt and flags:
- `int_ack` clears `cpu_int`, `overrun` and `sync_err`.
- If `int_ack` and the DONE set of `cpu_int` occur in the same cycle, set wins: `cpu_int` stays 1. Flags set in that cycle also remain set.

Other rules:
- `f0_start` and `c4_fall` in the same cycle: `f0_start` has priority and that `c4` edge is discarded.
- `bit_idx` never exceeds FRAME_BITS-1 and does not wrap inside a frame. It holds its last value in IDLE.
- `select` changes mid-frame have no effect until the next frame start.
- `reset_rg` mid-frame aborts to IDLE within the same clock. No `shift_en` or `frame_done` is issued for the aborted frame.

## Timing
- Reset values: `shift_en`=0, `bit_idx`=0, `dir`=0, `frame_done`=0, `cpu_int`=0, `overrun`=0, `sync_err`=0; FSM = IDLE.
- Pin edge → `c4_fall`/`f0_start` pulse: 3 `clk50` cycles, ±1 for metastability resolution.
- `f0_start` at cycle N → state RUN at N+1. `dir` is valid at N+1.
- `c4_fall` at cycle M → `shift_en` registered and high at M+1, for exactly one cycle.
- Last `shift_en` at cycle K → `frame_done` and `cpu_int` rise at K+1.
- `int_ack` at cycle A → `cpu_int` low at A+1.
- `shift_en` spacing is at least 2 `clk50` cycles whenever the `c4` period is at least 4 `clk50` periods (80 ns). Faster `c4` is unsupported.

## Configuration
Macro: `CONV_RESYNC_EN`.
- Defined: an `f0_start` in RUN restarts the frame.
  - `bit_idx` ← 0, phase ← 0, `dir` ← `select`.
  - `sync_err` is set.
  - No `frame_done` is issued for the truncated frame.
- Undefined: an `f0_start` in RUN only sets `sync_err`.
  - Counting continues to FRAME_BITS.
  - The next frame starts only on an `f0_start` seen in IDLE.

## Test plan
1. Reset, then `f0` low pulse, then 768 `c4` cycles with C4_PER_BIT=2 → 384 `shift_en` pulses with `bit_idx` 0..383, then `frame_done` once, `cpu_int`=1, `overrun`=0.
2. `select`=1 at frame start, toggle `select` to 0 mid-frame → `dir`=1 for the whole frame; `dir`=0 after the next `f0`.
3. Two full frames with no `int_ack` → `overrun`=1 after the second `frame_done`. Then `int_ack` → `cpu_int`, `overrun` and `sync_err` all 0 next cycle.
4. `f0` again after bit 100:
   - With `CONV_RESYNC_EN`: `sync_err`=1, `bit_idx` restarts at 0, first `frame_done` only after 384 more bits.
   - Without it: `sync_err`=1, `frame_done` after bit 383 of the original frame.
5. `reset_rg` asserted at bit 200 for one cycle → no further `shift_en`, all outputs 0, IDLE. The next `f0` starts at `bit_idx` 0.
6. `int_ack` in the same cycle as DONE → `cpu_int` remains 1.
